// File: rtl/arb_mux2_bits_stage.sv
// Two-input round-robin ready/valid arbiter driving a registered 2:1 mux stage.
// Optional packet locking (no interleaving inside a packet) via `ARB_MUX_PACKET_LOCK_EN.
module arb_mux2_bits_stage #(
    parameter int WIDTH = 2
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [WIDTH-1:0] I0_data,
    input  logic             I0_valid,
    output logic             I0_ready,
    input  logic [WIDTH-1:0] I1_data,
    input  logic             I1_valid,
    output logic             I1_ready,
`ifdef ARB_MUX_PACKET_LOCK_EN
    input  logic             I0_last,
    input  logic             I1_last,
    output logic             O_last,
`endif
    output logic             S,
    output logic [WIDTH-1:0] O_data,
    output logic             O_valid,
    input  logic             O_ready
);

    logic [WIDTH-1:0] o_data_q, o_data_d;
    logic             o_valid_q, o_valid_d;
    logic             last_grant_q, last_grant_d;
    logic             lock_active;
    logic             accept;
    logic             grant;
    logic             i0_ready, i1_ready;
    logic             xfer;

`ifdef ARB_MUX_PACKET_LOCK_EN
    logic lock_q, lock_d;
    logic o_last_q, o_last_d;
    logic mux_last;

    assign lock_active = lock_q;
`else
    assign lock_active = 1'b0;
`endif

    always_comb begin
        accept = !o_valid_q || O_ready;

        // With no requester the select parks on the previous winner to avoid toggling.
        grant = last_grant_q;
        if (!lock_active) begin
            case ({I1_valid, I0_valid})
                2'b01:   grant = 1'b0;
                2'b10:   grant = 1'b1;
                2'b11:   grant = !last_grant_q;
                default: grant = last_grant_q;
            endcase
        end

        i0_ready = !ASYNCRESET && accept && I0_valid && !grant;
        i1_ready = !ASYNCRESET && accept && I1_valid && grant;
        xfer     = i0_ready || i1_ready;

        o_valid_d    = o_valid_q;
        o_data_d     = o_data_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            o_valid_d    = 1'b1;
            o_data_d     = grant ? I1_data : I0_data;
            last_grant_d = grant;
        end else if (o_valid_q && O_ready) begin
            o_valid_d = 1'b0;
        end
    end

`ifdef ARB_MUX_PACKET_LOCK_EN
    always_comb begin
        mux_last = grant ? I1_last : I0_last;
        lock_d   = lock_q;
        o_last_d = o_last_q;
        if (xfer) begin
            lock_d   = !mux_last;
            o_last_d = mux_last;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            lock_q   <= 1'b0;
            o_last_q <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            o_last_q <= o_last_d;
        end
    end

    assign O_last = o_last_q;
`endif

    // last_grant resets to 1 so that I0 wins the first contended cycle.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            o_data_q     <= '0;
            o_valid_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            o_data_q     <= o_data_d;
            o_valid_q    <= o_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign S        = grant;
    assign I0_ready = i0_ready;
    assign I1_ready = i1_ready;
    assign O_data   = o_data_q;
    assign O_valid  = o_valid_q;

endmodule

// File: tb/tb_arb_mux2_bits_stage.sv
// Scoreboard bench for arb_mux2_bits_stage: directed vectors push expected words,
// a negedge monitor pops and compares whenever the output is consumed.
module tb_arb_mux2_bits_stage;

    logic       CLK = 1'b0;
    logic       ASYNCRESET;
    logic [1:0] I0_data, I1_data, O_data;
    logic       I0_valid, I1_valid, I0_ready, I1_ready;
    logic       I0_last, I1_last;
    logic       S, O_valid, O_ready;
`ifdef ARB_MUX_PACKET_LOCK_EN
    logic       O_last;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic [1:0] exp_q[$];

    always #5 CLK = ~CLK;

    arb_mux2_bits_stage #(.WIDTH(2)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .I0_data    (I0_data),
        .I0_valid   (I0_valid),
        .I0_ready   (I0_ready),
        .I1_data    (I1_data),
        .I1_valid   (I1_valid),
        .I1_ready   (I1_ready),
`ifdef ARB_MUX_PACKET_LOCK_EN
        .I0_last    (I0_last),
        .I1_last    (I1_last),
        .O_last     (O_last),
`endif
        .S          (S),
        .O_data     (O_data),
        .O_valid    (O_valid),
        .O_ready    (O_ready)
    );

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // One cycle: drive just after the rising edge, check combinational outputs,
    // and queue the word that should be captured at the following edge.
    task automatic step(input logic i0v, input logic [1:0] i0d, input logic l0,
                        input logic i1v, input logic [1:0] i1d, input logic l1,
                        input logic ordy, input logic e_ov, input logic e_s,
                        input logic e_r0, input logic e_r1, input string tag);
        @(posedge CLK);
        #1;
        I0_valid = i0v; I0_data = i0d; I0_last = l0;
        I1_valid = i1v; I1_data = i1d; I1_last = l1;
        O_ready  = ordy;
        #1;
        chk({tag, " O_valid"},  {1'b0, O_valid},  {1'b0, e_ov});
        chk({tag, " S"},        {1'b0, S},        {1'b0, e_s});
        chk({tag, " I0_ready"}, {1'b0, I0_ready}, {1'b0, e_r0});
        chk({tag, " I1_ready"}, {1'b0, I1_ready}, {1'b0, e_r1});
        if (e_r0) exp_q.push_back(i0d);
        if (e_r1) exp_q.push_back(i1d);
    endtask

    always @(negedge CLK) begin
        if (!ASYNCRESET && O_valid && O_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL monitor: unexpected word %b, none expected", O_data);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (O_data === e) n_pass++;
                else $display("FAIL monitor O_data: got %b expected %b", O_data, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ASYNCRESET = 1'b1;
        I0_valid = 1'b1; I0_data = 2'b11; I0_last = 1'b1;
        I1_valid = 1'b0; I1_data = 2'b00; I1_last = 1'b1;
        O_ready = 1'b1;
        #12;
        chk("reset O_valid",  {1'b0, O_valid},  2'b00);
        chk("reset O_data",   O_data,           2'b00);
        chk("reset I0_ready", {1'b0, I0_ready}, 2'b00);
        I0_valid = 1'b0;
        #2 ASYNCRESET = 1'b0;

        //      i0v i0d  l0   i1v i1d  l1   rdy ov   s    r0   r1
        step(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "single_i0");
        step(1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "single_i1");
        chk("latency O_data", O_data, 2'b10);
        for (int k = 0; k < 4; k++)
            step(1'b1, 2'b01, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, k[0], !k[0], k[0], "rr");

        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'b01, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "stall");
            chk("stall O_data", O_data, 2'b11);
        end
        step(1'b1, 2'b01, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "resume0");
        step(1'b1, 2'b01, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "resume1");

        step(1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "nobubble");
        step(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "nobubble_hold");
        chk("nobubble O_data", O_data, 2'b00);
        step(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "drained");

        step(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "pre_reset");
        step(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "held");
        chk("held O_data", O_data, 2'b11);
        #1 ASYNCRESET = 1'b1; I0_valid = 1'b1;
        #1;
        chk("midreset O_valid",  {1'b0, O_valid},  2'b00);
        chk("midreset O_data",   O_data,           2'b00);
        chk("midreset I0_ready", {1'b0, I0_ready}, 2'b00);
        exp_q.delete();
        I0_valid = 1'b0;
        #1 ASYNCRESET = 1'b0;
        step(1'b1, 2'b10, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "post_reset");
        step(1'b1, 2'b10, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "post_reset2");

`ifdef ARB_MUX_PACKET_LOCK_EN
        step(1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "pkt0");
        step(1'b1, 2'b01, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "pkt1");
        step(1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "pkt2");
        step(1'b1, 2'b01, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "pkt_after");
        chk("pkt O_last", {1'b0, O_last}, 2'b01);
`endif

        step(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, S, 1'b0, 1'b0, "flush");
        step(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, S, 1'b0, 1'b0, "idle");
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard: %0d words left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arb_mux2_bits_stage.md
Name: arb_mux2_bits_stage

Overview:
- Two-input ready/valid round-robin arbiter with a registered output.
- Computes the select for a 2:1 Bits(WIDTH) mux, steers the winning input's data through it, and registers the result.
- Sits directly upstream of the downstream consumer and owns the mux select (exported on S).
- Full throughput: one transfer per cycle when the output is drained every cycle.

Parameters:
- WIDTH, 2, data width of each input and of the output.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- ASYNCRESET  input  1  asynchronous, active-high reset.
- I0_data  input  WIDTH  data, requester 0.
- I0_valid  input  1  requester 0 has data.
- I0_ready  output  1  requester 0 transfer accepted this cycle.
- I1_data  input  WIDTH  data, requester 1.
- I1_valid  input  1  requester 1 has data.
- I1_ready  output  1  requester 1 transfer accepted this cycle.
- S  output  1  combinational mux select / current grant (0 = I0, 1 = I1).
- O_data  output  WIDTH  registered output data.
- O_valid  output  1  output register holds data.
- O_ready  input  1  downstream accepts O_data this cycle.

Behaviour:
- Reset values (asynchronous on ASYNCRESET high): O_valid=0, O_data=0, last_grant=1, so I0 has first priority.
- While reset is asserted: I0_ready=0 and I1_ready=0.
- Reset mid-transfer drops the held word; the next transfer after release starts with I0 priority.
- accept = !O_valid || O_ready. The output register can load this cycle; back-to-back transfers are allowed.
- Grant (combinational):
  - only I0_valid -> 0;
  - only I1_valid -> 1;
  - both valid -> !last_grant;
  - neither valid -> S holds last_grant (no glitch toward idle input).
- S = grant. Ix_ready = accept && Ix_valid && (grant==x). At most one ready is high per cycle.
- Transfer on Ix_valid && Ix_ready:
  - at the next edge O_data <= Ix_data (selected via S), O_valid <= 1, last_grant <= x;
  - latency is 1 cycle from handshake to O_valid.
- Drain: O_valid && O_ready with no new transfer -> O_valid <= 0; O_data holds its stale value.
- Simultaneous drain and transfer in the same cycle: the new word loads, O_valid stays 1, no bubble.
- Stall: O_valid && !O_ready.
  - Both readies are 0 and O_data/O_valid hold.
  - Grant may still change combinationally with valids, but last_grant does not update.
- Fairness: with both inputs continuously valid and O_ready=1, grants alternate 0,1,0,1 every cycle.
- Valid/data from requesters need not be held stable before the handshake; only the handshake cycle's data is captured.
- Width rule: data is passed through unmodified; no truncation or extension.

Optional Feature:
- Macro ARB_MUX_PACKET_LOCK_EN.
- When defined:
  - adds input ports I0_last and I1_last (1 bit each) and output O_last (registered alongside O_data; reset 0);
  - adds a lock flag (reset 0): set when a transfer occurs with Ix_last=0, cleared when a transfer occurs with Ix_last=1;
  - while lock=1, grant is forced to last_grant regardless of the other input's valid, so packets are never interleaved;
  - ASYNCRESET clears lock.
- When undefined: no last ports, no lock flag; arbitration is per-word as described above.

Test Plan:
- Reset, then I0_valid=1, I0_data=2'b10, O_ready=1 -> I0_ready=1, S=0 same cycle; next cycle O_valid=1, O_data=2'b10.
- I0_valid=I1_valid=1 continuously, I0_data=2'b01, I1_data=2'b11, O_ready=1 -> O_data sequence 01,11,01,11; S alternates 0,1,0,1.
- Load one word, then O_ready=0 for 3 cycles with both valids high -> O_data/O_valid hold; I0_ready=I1_ready=0; after O_ready=1 transfers resume with the round-robin order intact.
- O_valid=1 with O_ready=1 and I1_valid=1, I1_data=2'b00 in the same cycle -> O_valid stays 1, O_data becomes 00 next cycle, no bubble.
- ASYNCRESET pulsed mid-cycle while O_valid=1 -> O_valid=0 and O_data=0 immediately (not at an edge); first contended grant afterwards goes to I0.
- With ARB_MUX_PACKET_LOCK_EN: I1 sends 3 words with last=0,0,1 while I0_valid=1 throughout -> all 3 I1 words are output consecutively, then I0 is granted; O_last=1 on the third word.
